// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - state encoding and load/store size codes for the data cache
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } dcache_state_t;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

endpackage

// File: rtl/data_cache_if.sv
// rtl/data_cache_if.sv - CPU memory-stage and backing-memory signals of the data cache
interface data_cache_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_req_i;
    logic                  cpu_we_i;
    logic [2:0]            cpu_memctrl_i;
    logic [ADDR_WIDTH-1:0] cpu_addr_i;
    logic [31:0]           cpu_wdata_i;
    logic [31:0]           cpu_rdata_o;
    logic                  cpu_stall_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_wdata_o;
    logic [3:0]            mem_wstrb_o;
    logic [31:0]           mem_rdata_i;
    logic                  mem_ready_i;

    // The cache itself
    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_memctrl_i, cpu_addr_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        input  mem_rdata_i, mem_ready_i
    );

    // The pipeline plus backing memory around the cache
    modport master (
        output cpu_req_i, cpu_we_i, cpu_memctrl_i, cpu_addr_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
        output mem_rdata_i, mem_ready_i
    );

endinterface

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store strobe/lane replication and load lane extraction
module mem_align
    import dcache_pkg::*;
(
    input  logic [2:0]  st_memctrl,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    input  logic [2:0]  ld_memctrl,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] rdata
);

    logic [15:0] ld_shifted;

    // Stores: strobes shift with the offset (misaligned ones simply truncate), data sits in every lane
    always_comb begin
        wstrb = 4'b0000;
        wdata = st_data;
        case (st_memctrl)
            MEM_B: begin
                wstrb = 4'b0001 << st_offset;
                wdata = {4{st_data[7:0]}};
            end
            MEM_H: begin
                wstrb = 4'b0011 << st_offset;
                wdata = {2{st_data[15:0]}};
            end
            MEM_W:   wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

    // Loads: bring the addressed lane down to bit 0, then sign/zero extend; words pass untouched
    always_comb begin
        ld_shifted = 16'(ld_word >> {ld_offset, 3'b000});
        case (ld_memctrl)
            MEM_B:   rdata = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
            MEM_BU:  rdata = {24'h0, ld_shifted[7:0]};
            MEM_H:   rdata = {{16{ld_shifted[15]}}, ld_shifted};
            MEM_HU:  rdata = {16'h0, ld_shifted};
            default: rdata = ld_word;
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-through data cache; DCACHE_PERF_CNT_EN adds hit/miss counters
module data_cache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = 64
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef DCACHE_PERF_CNT_EN
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o,
`endif
    data_cache_if.slave bus
);

    localparam int INDEX_BITS = $clog2(SETS);
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;

    dcache_state_t         state;
    logic [SETS-1:0]       valid_q;
    logic [TAG_BITS-1:0]   tag_mem  [SETS];
    logic [DATA_WIDTH-1:0] data_mem [SETS];

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_wdata;
    logic [2:0]            lat_memctrl;

    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [INDEX_BITS-1:0] cur_index;
    logic [TAG_BITS-1:0]   cur_tag;
    logic                  hit;
    logic                  mem_done;

    logic [2:0]            ld_memctrl;
    logic [31:0]           ld_word;
    logic [3:0]            st_wstrb;
    logic [31:0]           st_wdata;
    logic [31:0]           ld_rdata;

    // In IDLE the live CPU request is looked up; once a transaction is open, the latched one is
    assign cur_addr  = (state == IDLE) ? bus.cpu_addr_i : lat_addr;
    assign cur_index = cur_addr[INDEX_BITS+1:2];
    assign cur_tag   = cur_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit       = valid_q[cur_index] && (tag_mem[cur_index] == cur_tag);
    assign mem_done  = (state != IDLE) && bus.mem_ready_i;

    assign ld_memctrl = (state == IDLE) ? bus.cpu_memctrl_i : lat_memctrl;
    assign ld_word    = (state == REFILL) ? bus.mem_rdata_i : data_mem[cur_index];

    mem_align u_mem_align (
        .st_memctrl (lat_memctrl),
        .st_offset  (lat_addr[1:0]),
        .st_data    (lat_wdata),
        .ld_memctrl (ld_memctrl),
        .ld_offset  (cur_addr[1:0]),
        .ld_word    (ld_word),
        .wstrb      (st_wstrb),
        .wdata      (st_wdata),
        .rdata      (ld_rdata)
    );

    // Memory side is driven purely from state and latched registers so it holds steady while waiting
    assign bus.mem_req_o   = (state != IDLE);
    assign bus.mem_we_o    = (state == WRITE);
    assign bus.mem_addr_o  = {lat_addr[ADDR_WIDTH-1:2], 2'b00};
    assign bus.mem_wdata_o = st_wdata;
    assign bus.mem_wstrb_o = (state == WRITE) ? st_wstrb : 4'b0000;

    // Pipeline stall and load result: hits answer at once, misses answer on the refill beat
    always_comb begin
        bus.cpu_stall_o = 1'b0;
        bus.cpu_rdata_o = 32'h0;
        case (state)
            IDLE: begin
                if (bus.cpu_req_i) begin
                    bus.cpu_stall_o = bus.cpu_we_i || !hit;
                    if (!bus.cpu_we_i && hit) begin
                        bus.cpu_rdata_o = ld_rdata;
                    end
                end
            end
            REFILL: begin
                bus.cpu_stall_o = !bus.mem_ready_i;
                if (bus.mem_ready_i) begin
                    bus.cpu_rdata_o = ld_rdata;
                end
            end
            WRITE:   bus.cpu_stall_o = !bus.mem_ready_i;
            default: bus.cpu_stall_o = 1'b0;
        endcase
    end

    // Control FSM: latch misses and stores, wait for the one-cycle ready, mark refilled lines valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            valid_q     <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_memctrl <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req_i && (bus.cpu_we_i || !hit)) begin
                        lat_addr    <= bus.cpu_addr_i;
                        lat_wdata   <= bus.cpu_wdata_i;
                        lat_memctrl <= bus.cpu_memctrl_i;
                        state       <= bus.cpu_we_i ? WRITE : REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_ready_i) begin
                        valid_q[cur_index] <= 1'b1;
                        state              <= IDLE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays: fill on refill, patch strobed bytes on a store hit; a reset edge writes nothing
    always_ff @(posedge clk) begin
        if (rst_n && mem_done) begin
            if (state == REFILL) begin
                tag_mem[cur_index]  <= cur_tag;
                data_mem[cur_index] <= bus.mem_rdata_i;
            end else if (hit) begin
                for (int i = 0; i < 4; i++) begin
                    if (st_wstrb[i]) begin
                        data_mem[cur_index][8*i +: 8] <= st_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // Completed-load statistics; misses count when their refill returns
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_o  <= 32'h0;
            miss_cnt_o <= 32'h0;
        end else begin
            if (state == IDLE && bus.cpu_req_i && !bus.cpu_we_i && hit) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (state == REFILL && bus.mem_ready_i) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter DATA_WIDTH, 32, word width in bits; only 32 is supported.
REQ-002 Parameter ADDR_WIDTH, 32, byte address width.
REQ-003 Parameter SETS, 64, number of direct-mapped one-word lines; power of two; INDEX_BITS = log2(SETS).
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port rst_n, input, 1: reset; synchronous, active-low.
REQ-006 Port cpu_req_i, input, 1: memory-stage access request valid.
REQ-007 Port cpu_we_i, input, 1: 1 = store, 0 = load.
REQ-008 Port cpu_memctrl_i, input, 3: funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 Port cpu_addr_i, input, ADDR_WIDTH: byte address.
REQ-010 Port cpu_wdata_i, input, 32: store data, right-aligned.
REQ-011 Port cpu_rdata_o, output, 32: load result, extended per memctrl.
REQ-012 Port cpu_stall_o, output, 1: drives the pipeline en_m (en_m = !cpu_stall_o).
REQ-013 Port mem_req_o / mem_we_o, output, 1 each: backing-memory request and direction.
REQ-014 Port mem_addr_o, output, ADDR_WIDTH: word-aligned address (bits [1:0] = 0).
REQ-015 Port mem_wdata_o, output, 32 / mem_wstrb_o, output, 4: lane-aligned store data and byte strobes.
REQ-016 Port mem_rdata_i, input, 32 / mem_ready_i, input, 1: read word; one-cycle completion pulse.

Function
REQ-017 Address split SHALL be: offset [1:0], index [INDEX_BITS+1:2], tag [ADDR_WIDTH-1:INDEX_BITS+2].
REQ-018 Hit SHALL be computed combinationally: valid[index] && tag match.
REQ-019 FSM states SHALL be IDLE, REFILL and WRITE.
REQ-020 IDLE, load hit: cpu_stall_o = 0 and cpu_rdata_o = extracted line data in the same cycle (zero latency).
REQ-021 IDLE, load miss: cpu_stall_o = 1, the request is latched, and the FSM goes to REFILL.
REQ-022 IDLE, any store: cpu_stall_o = 1, address/data/memctrl are latched, and the FSM goes to WRITE.
REQ-023 REFILL: mem_req_o = 1 and mem_we_o = 0 until mem_ready_i.
 - Completion cycle: line data = mem_rdata_i; tag written; valid set.
 - cpu_rdata_o = extract(mem_rdata_i); cpu_stall_o = 0; next state IDLE.
REQ-024 WRITE (write-through, no-write-allocate): mem_req_o = 1 and mem_we_o = 1 until mem_ready_i.
 - Completion cycle: if hit, the line bytes selected by mem_wstrb_o are updated (valid/tag unchanged); if miss, the cache is unchanged.
 - cpu_stall_o = 0 in the completion cycle; next state IDLE.
REQ-025 cpu_stall_o SHALL be 1 in REFILL and WRITE whenever mem_ready_i = 0.
REQ-026 Strobes: SB -> 4'b0001 << offset; SH -> 4'b0011 << offset; SW -> 4'b1111. Write data SHALL be replicated into the byte lanes.
REQ-027 Loads: B/H sign-extend; BU/HU zero-extend; W passes through. The lane is selected by the offset.
REQ-028 Misaligned halfword/word accesses SHALL use offset bits as-is and are not trapped.
REQ-029 cpu_req_i = 0 in IDLE: no stall; mem_req_o = 0; state held.
REQ-030 mem_ready_i while IDLE SHALL be ignored.
REQ-031 Outputs SHALL be stable while waiting; mem_addr_o and mem_wdata_o come from latched registers, not CPU inputs.

Reset
REQ-032 rst_n = 0 at an edge SHALL produce: state IDLE, all valid bits 0, latched registers 0.
 - Post-reset outputs: cpu_stall_o = 0, mem_req_o = 0, mem_we_o = 0, mem_wstrb_o = 0, cpu_rdata_o = 0.
REQ-033 Reset during REFILL/WRITE SHALL abandon the transaction; no line is written. The memory side tolerates mem_req_o dropping.
REQ-034 Tag/data arrays need no reset.

Configuration
REQ-035 With DCACHE_PERF_CNT_EN defined, outputs hit_cnt_o and miss_cnt_o (32 bits each) SHALL exist.
 - Each increments once per completed IDLE load hit or load miss; they wrap at 2^32 and are cleared by rst_n.
 - Without the macro, neither the ports nor the counters exist, and the remaining behaviour is identical.

Structure
REQ-036 Package dcache_pkg SHALL hold the state enum and funct3 constants (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU).
REQ-037 Sub-module mem_align SHALL perform the combinational strobe/lane alignment and load extraction; it is instantiated once.

Verification
REQ-038 After reset, LW 0x100: stall 1 in the detect cycle plus the REFILL wait. With mem_rdata_i = 0xDEADBEEF and ready on REFILL cycle 3, cpu_rdata_o = 0xDEADBEEF with stall 0 that cycle. Next LW 0x100 hits with zero stall.
REQ-039 Line holds 0x80FF7F01: LB 0x101 -> 0x0000007F; LB 0x103 -> 0xFFFFFF80; LHU 0x102 -> 0x000080FF; LH 0x102 -> 0xFFFF80FF.
REQ-040 SB 0x102 data 0xAB on a hit: mem_wstrb_o = 4'b0100, mem_wdata_o[23:16] = 0xAB. After ready, LW 0x100 hits and returns the old word with byte 2 = 0xAB.
REQ-041 SW to a missing line 0x200, then LW 0x200: the store causes no allocation and the load misses (mem_we_o = 0 refill).
REQ-042 Conflict: LW 0x000, then LW 0x100 (SETS = 64, same index, different tag) -> miss; a subsequent LW 0x000 misses again.
REQ-043 Assert rst_n = 0 mid-REFILL: next cycle mem_req_o = 0 and stall = 0. A retried LW to the same address misses. With DCACHE_PERF_CNT_EN defined, counters read 0 after reset.
